// File: rtl/byte_striping_param.sv
// Round-robin byte striper: gathers LANES serial words into one lane-parallel
// group with valid/ready output, padded partial-group flush and sticky drop flag.
module byte_striping_param #(
  parameter int                WIDTH = 8,
  parameter int                LANES = 4,
  parameter logic [WIDTH-1:0]  PAD   = 8'hBC
) (
  input  logic                         clk1Mhz,
  input  logic                         reset,
  input  logic                         ENB,
  input  logic [WIDTH-1:0]             byteStripingIN,
  input  logic                         laneVLD,
  input  logic                         flush,
  input  logic                         outREADY,
  output logic                         inREADY,
  output logic [LANES*WIDTH-1:0]       stripedLanes,
  output logic [LANES-1:0]             stripedMask,
  output logic                         byteStripingVLD,
  output logic [$clog2(LANES)-1:0]     counter,
  output logic                         dropErr
);

  localparam int             CW   = $clog2(LANES);
  localparam int             NW   = CW + 1;
  localparam logic [CW-1:0]  LAST = CW'(LANES - 1);

  // Handshake: an input word transfers on an edge where laneVLD && inREADY;
  // an output group transfers on an edge where byteStripingVLD && outREADY,
  // and the group stays stable until that edge.

  logic [WIDTH-1:0]       gather   [LANES];
  logic [WIDTH-1:0]       gather_n [LANES];
  logic                   flush_pend;
  logic                   out_free;
  logic                   accept;
  logic                   grp_full;
  logic                   flush_act;
  logic                   flush_go;
  logic [NW-1:0]          fill_cnt;
  logic [LANES*WIDTH-1:0] lanes_n;
  logic [LANES-1:0]       mask_n;

  assign out_free  = !byteStripingVLD || outREADY;
  assign inREADY   = ENB && ((counter != LAST) || out_free);
  assign accept    = laneVLD && inREADY;
  assign grp_full  = accept && (counter == LAST);
  // fill_cnt counts the lanes holding real data once this edge's word lands.
  assign fill_cnt  = {1'b0, counter} + {{CW{1'b0}}, accept};
  assign flush_act = flush || flush_pend;
  assign flush_go  = flush_act && !grp_full && (fill_cnt != '0) && out_free;

  // The outgoing group is built from the gather buffer as it will look after
  // this edge, so a full group and a flushed partial share one path.
  always_comb begin
    gather_n = gather;
    lanes_n  = '0;
    mask_n   = '0;
    if (accept) gather_n[counter] = byteStripingIN;
    for (int i = 0; i < LANES; i++) begin
      if (NW'(i) < fill_cnt) begin
        lanes_n[i*WIDTH +: WIDTH] = gather_n[i];
        mask_n[i]                 = 1'b1;
      end else begin
        lanes_n[i*WIDTH +: WIDTH] = PAD;
      end
    end
  end

  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      counter         <= '0;
      flush_pend      <= 1'b0;
      byteStripingVLD <= 1'b0;
      stripedLanes    <= '0;
      stripedMask     <= '0;
      dropErr         <= 1'b0;
      for (int i = 0; i < LANES; i++) gather[i] <= '0;
    end else begin
      gather <= gather_n;
      if (ENB && laneVLD && !inREADY) dropErr <= 1'b1;

      if (grp_full || flush_go) begin
        stripedLanes    <= lanes_n;
        stripedMask     <= mask_n;
        byteStripingVLD <= 1'b1;
        counter         <= '0;
      end else begin
        if (accept) counter <= counter + 1'b1;
        if (byteStripingVLD && outREADY) byteStripingVLD <= 1'b0;
      end

      // A pending flush survives only while data is waiting on a full output.
      if (grp_full || flush_go)
        flush_pend <= 1'b0;
      else if (flush_act && (fill_cnt == '0))
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_striping_param.sv
// Bench for byte_striping_param: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_byte_striping_param;

  localparam int          WIDTH = 8;
  localparam int          LANES = 4;
  localparam logic [7:0]  PAD   = 8'hBC;
  localparam int          DW    = LANES * WIDTH;

  logic             clk1Mhz = 1'b0;
  logic             reset;
  logic             ENB;
  logic [WIDTH-1:0] byteStripingIN;
  logic             laneVLD;
  logic             flush;
  logic             outREADY;
  logic             inREADY;
  logic [DW-1:0]    stripedLanes;
  logic [LANES-1:0] stripedMask;
  logic             byteStripingVLD;
  logic [1:0]       counter;
  logic             dropErr;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk1Mhz = ~clk1Mhz;

  byte_striping_param #(.WIDTH(WIDTH), .LANES(LANES), .PAD(PAD)) dut (
    .clk1Mhz         (clk1Mhz),
    .reset           (reset),
    .ENB             (ENB),
    .byteStripingIN  (byteStripingIN),
    .laneVLD         (laneVLD),
    .flush           (flush),
    .outREADY        (outREADY),
    .inREADY         (inREADY),
    .stripedLanes    (stripedLanes),
    .stripedMask     (stripedMask),
    .byteStripingVLD (byteStripingVLD),
    .counter         (counter),
    .dropErr         (dropErr)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] din;
    logic       fl;
    logic       ordy;
    int         rdy;    // -1: inREADY not checked on this row
    logic       ovld;
    logic [31:0] lanes;
    logic [3:0] mask;
    int         cnt;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, en, vld, input logic [7:0] din,
                     input logic fl, ordy, input int rdy, input logic ovld,
                     input logic [31:0] lanes, input logic [3:0] mask,
                     input int cnt, input logic drop);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.din = din; v.fl = fl; v.ordy = ordy;
    v.rdy = rdy; v.ovld = ovld; v.lanes = lanes; v.mask = mask; v.cnt = cnt;
    v.drop = drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // reference model: words waiting in a queue, groups expected in exp_q
  logic [7:0]         gq[$];
  logic [DW+LANES-1:0] exp_q[$];
  bit                 m_fp;
  bit                 m_vld;
  bit                 m_drop;
  logic [DW-1:0]      m_lanes;
  logic [LANES-1:0]   m_mask;

  task automatic model_emit();
    for (int i = 0; i < LANES; i++) begin
      m_lanes[i*WIDTH +: WIDTH] = (i < gq.size()) ? gq[i] : PAD;
      m_mask[i]                 = (i < gq.size());
    end
    m_vld = 1'b1;
    exp_q.push_back({m_mask, m_lanes});
    gq.delete();
  endtask

  // driver: one cycle of stimulus with model prediction and comparison
  task automatic step(input bit rst, en, vld, input logic [7:0] din, input bit fl, ordy);
    bit exp_rdy;
    bit free;
    logic [DW+LANES-1:0] got;
    reset = rst; ENB = en; laneVLD = vld; byteStripingIN = din; flush = fl; outREADY = ordy;
    #1;
    exp_rdy = en && ((gq.size() != LANES - 1) || !m_vld || ordy);
    chk("m_inready", inREADY, exp_rdy);
    if (!rst && byteStripingVLD && ordy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_group got=%0h want=none", stripedLanes);
      end else begin
        got = {stripedMask, stripedLanes};
        chk("sb_group", got, exp_q.pop_front());
      end
    end
    @(posedge clk1Mhz); #1;
    if (rst) begin
      gq.delete(); exp_q.delete();
      m_fp = 0; m_vld = 0; m_drop = 0; m_lanes = '0; m_mask = '0;
    end else begin
      free = !m_vld || ordy;
      if (en && vld && !exp_rdy) m_drop = 1;
      if (m_vld && ordy) m_vld = 0;
      if (vld && exp_rdy) gq.push_back(din);
      if (gq.size() == LANES) begin
        model_emit();
        m_fp = 0;
      end else if (fl || m_fp) begin
        if (gq.size() == 0) m_fp = 0;
        else if (free) begin model_emit(); m_fp = 0; end
        else m_fp = 1;
      end
    end
    chk("m_vld", byteStripingVLD, m_vld);
    chk("m_cnt", counter, gq.size());
    chk("m_drop", dropErr, m_drop);
    if (m_vld || rst) begin
      chk("m_lanes", stripedLanes, m_lanes);
      chk("m_mask", stripedMask, m_mask);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; ENB = 1'b0; laneVLD = 1'b0; byteStripingIN = '0; flush = 1'b0; outREADY = 1'b0;

    // reset, 4-word group, partial flush, flush at counter 0
    add(1,0,0,8'h00,0,1, -1,0,32'h0,4'h0,0,0);
    add(0,1,1,8'h11,0,1, 1,0,0,0,1,0);
    add(0,1,1,8'h22,0,1, 1,0,0,0,2,0);
    add(0,1,1,8'h33,0,1, 1,0,0,0,3,0);
    add(0,1,1,8'h44,0,1, 1,1,32'h44332211,4'hF,0,0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);
    add(0,1,1,8'h55,0,1, 1,0,0,0,1,0);
    add(0,1,1,8'h66,0,1, 1,0,0,0,2,0);
    add(0,1,0,8'h00,1,1, 1,1,32'hBCBC6655,4'h3,0,0);
    add(0,1,0,8'h00,1,1, 1,0,0,0,0,0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);
    // eight back-to-back words
    for (int k = 1; k <= 8; k++)
      add(0,1,1,8'(k),0,1, 1,(k % 4 == 0),
          (k == 4) ? 32'h04030201 : (k == 8) ? 32'h08070605 : 32'h0,
          (k % 4 == 0) ? 4'hF : 4'h0, k % 4, 0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);
    // held output, next group blocks at its last word
    add(0,1,1,8'hB1,0,0, 1,0,0,0,1,0);
    add(0,1,1,8'hB2,0,0, 1,0,0,0,2,0);
    add(0,1,1,8'hB3,0,0, 1,0,0,0,3,0);
    add(0,1,1,8'hB4,0,0, 1,1,32'hB4B3B2B1,4'hF,0,0);
    add(0,1,1,8'hA1,0,0, 1,1,32'hB4B3B2B1,4'hF,1,0);
    add(0,1,1,8'hA2,0,0, 1,1,32'hB4B3B2B1,4'hF,2,0);
    add(0,1,1,8'hA3,0,0, 1,1,32'hB4B3B2B1,4'hF,3,0);
    add(0,1,0,8'h00,0,0, 0,1,32'hB4B3B2B1,4'hF,3,0);
    add(0,1,1,8'hA4,0,1, 1,1,32'hA4A3A2A1,4'hF,0,0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);
    // drop while blocked, sticky through traffic
    add(0,1,1,8'hC1,0,0, 1,0,0,0,1,0);
    add(0,1,1,8'hC2,0,0, 1,0,0,0,2,0);
    add(0,1,1,8'hC3,0,0, 1,0,0,0,3,0);
    add(0,1,1,8'hC4,0,0, 1,1,32'hC4C3C2C1,4'hF,0,0);
    add(0,1,1,8'hD1,0,0, 1,1,32'hC4C3C2C1,4'hF,1,0);
    add(0,1,1,8'hD2,0,0, 1,1,32'hC4C3C2C1,4'hF,2,0);
    add(0,1,1,8'hD3,0,0, 1,1,32'hC4C3C2C1,4'hF,3,0);
    add(0,1,1,8'hD4,0,0, 0,1,32'hC4C3C2C1,4'hF,3,1);
    add(0,1,1,8'hD4,0,1, 1,1,32'hD4D3D2D1,4'hF,0,1);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,1);
    add(0,1,0,8'h00,1,1, 1,0,0,0,0,1);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,1);
    add(0,1,1,8'hE0,0,1, 1,0,0,0,1,1);
    add(1,1,0,8'h00,0,1, 1,0,32'h0,4'h0,0,0);
    // reset mid-group with an output pending
    add(0,1,1,8'hE1,0,0, 1,0,0,0,1,0);
    add(0,1,1,8'hE2,0,0, 1,0,0,0,2,0);
    add(0,1,1,8'hE3,0,0, 1,0,0,0,3,0);
    add(0,1,1,8'hE4,0,0, 1,1,32'hE4E3E2E1,4'hF,0,0);
    add(0,1,1,8'hF1,0,0, 1,1,32'hE4E3E2E1,4'hF,1,0);
    add(0,1,1,8'hF2,0,0, 1,1,32'hE4E3E2E1,4'hF,2,0);
    add(1,1,1,8'hF3,0,0, 1,0,32'h0,4'h0,0,0);
    add(0,1,1,8'h71,0,1, 1,0,0,0,1,0);
    add(0,1,1,8'h72,0,1, 1,0,0,0,2,0);
    add(0,1,1,8'h73,0,1, 1,0,0,0,3,0);
    add(0,1,1,8'h74,0,1, 1,1,32'h74737271,4'hF,0,0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);
    // ENB low: no accept, no drop; flush still honoured with data waiting
    add(0,0,1,8'h99,0,1, 0,0,0,0,0,0);
    add(0,1,1,8'h77,0,1, 1,0,0,0,1,0);
    add(0,0,0,8'h00,1,1, 0,1,32'hBCBCBC77,4'h1,0,0);
    add(0,1,0,8'h00,0,1, 1,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset = v.rst; ENB = v.en; laneVLD = v.vld; byteStripingIN = v.din;
      flush = v.fl; outREADY = v.ordy;
      #1;
      if (v.rdy >= 0) chk($sformatf("row%0d_inready", i), inREADY, v.rdy);
      @(posedge clk1Mhz); #1;
      chk($sformatf("row%0d_vld", i), byteStripingVLD, v.ovld);
      chk($sformatf("row%0d_cnt", i), counter, v.cnt);
      chk($sformatf("row%0d_drop", i), dropErr, v.drop);
      if (v.ovld || v.rst) begin
        chk($sformatf("row%0d_lanes", i), stripedLanes, v.lanes);
        chk($sformatf("row%0d_mask", i), stripedMask, v.mask);
      end
    end

    // flush requested while the output is full: held, then honoured on drain
    step(1,0,0,8'h00,0,0);
    for (int k = 0; k < 4; k++) step(0,1,1,8'h30 + 8'(k),0,0);
    step(0,1,1,8'h41,0,0);
    step(0,1,1,8'h42,0,0);
    step(0,1,0,8'h00,1,0);
    step(0,1,0,8'h00,0,0);
    step(0,1,0,8'h00,0,0);
    step(0,1,0,8'h00,0,1);
    step(0,1,0,8'h00,0,1);
    // flush on the edge that completes a full group
    step(0,1,1,8'h51,0,1);
    step(0,1,1,8'h52,0,1);
    step(0,1,1,8'h53,0,1);
    step(0,1,1,8'h54,1,1);
    step(0,1,1,8'h61,0,1);
    step(0,1,0,8'h00,0,1);
    step(0,1,0,8'h00,1,1);

    // randomized traffic
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
           $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
